// File: rtl/led_serial_capture.sv
// rtl/led_serial_capture.sv - oversampling receiver and capture bank for the LED serial output bus
module led_serial_capture #(
  parameter int LANES = 12,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             serial_clk,
  input  logic             latch_enable,
  input  logic             output_enable_n,
  input  logic [LANES-1:0] serial_data_out,
  input  logic [15:0]      row_select_n,
  input  logic [3:0]       cap_lane_addr,
  input  logic             err_clear,
  output logic [DEPTH-1:0] cap_data,
  output logic [3:0]       cap_row,
  output logic [4:0]       cap_bit_count,
  output logic             cap_strobe,
  output logic [15:0]      latch_count,
  output logic             row_error,
  output logic             length_error,
  output logic             blank_error
);

  localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);
  localparam logic [4:0] LANES_LIM = 5'(LANES);

  logic             sclk_d;
  logic             le_d;
  // Held low through reset and for the first cycle after it, so a level that
  // is already high when reset releases is absorbed into sclk_d/le_d instead
  // of being seen as a rising edge.
  logic             armed;
  logic             shift_ev;
  logic             latch_ev;
  logic [DEPTH-1:0] sr      [LANES];
  logic [DEPTH-1:0] sr_next [LANES];
  logic [DEPTH-1:0] bank    [LANES];
  logic [4:0]       bit_cnt;
  logic [4:0]       cnt_next;
  logic [3:0]       addr_q;
  logic [3:0]       row_idx;
  logic [4:0]       zero_cnt;

  assign shift_ev = armed & serial_clk & ~sclk_d;
  assign latch_ev = armed & latch_enable & ~le_d;

  // Next shift-register and bit-count values; the latch path captures these so
  // a shift coinciding with a latch is included in the snapshot.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sr_next[i] = sr[i];
      if (shift_ev) begin
        sr_next[i]    = sr[i] << 1;
        sr_next[i][0] = serial_data_out[i];
      end
    end
    cnt_next = bit_cnt;
    if (shift_ev && bit_cnt != 5'd31) begin
      cnt_next = bit_cnt + 5'd1;
    end
  end

  // Row decode: count active-low bits and find the lowest-numbered one.
  always_comb begin
    zero_cnt = 5'd0;
    row_idx  = 4'd0;
    for (int j = 0; j < 16; j++) begin
      zero_cnt = zero_cnt + {4'd0, ~row_select_n[j]};
    end
    for (int j = 15; j >= 0; j--) begin
      if (!row_select_n[j]) begin
        row_idx = 4'(j);
      end
    end
  end

  // Previous-cycle levels for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_d <= 1'b0;
      le_d   <= 1'b0;
      armed  <= 1'b0;
    end else begin
      sclk_d <= serial_clk;
      le_d   <= latch_enable;
      armed  <= 1'b1;
    end
  end

  // Per-lane shift registers and the saturating bit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LANES; i++) begin
        sr[i] <= '0;
      end
      bit_cnt <= 5'd0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        sr[i] <= sr_next[i];
      end
      bit_cnt <= latch_ev ? 5'd0 : cnt_next;
    end
  end

  // Capture bank, latch metadata and strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LANES; i++) begin
        bank[i] <= '0;
      end
      cap_bit_count <= 5'd0;
      cap_row       <= 4'd0;
      latch_count   <= 16'd0;
      cap_strobe    <= 1'b0;
    end else begin
      cap_strobe <= latch_ev;
      if (latch_ev) begin
        for (int i = 0; i < LANES; i++) begin
          bank[i] <= sr_next[i];
        end
        cap_bit_count <= cnt_next;
        cap_row       <= row_idx;
        latch_count   <= latch_count + 16'd1;
      end
    end
  end

  // Sticky protocol error flags; a new violation overrides a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_error    <= 1'b0;
      length_error <= 1'b0;
      blank_error  <= 1'b0;
    end else begin
      row_error    <= (row_error & ~err_clear) | (latch_ev & (zero_cnt != 5'd1));
      length_error <= (length_error & ~err_clear) | (latch_ev & (cnt_next != DEPTH_CNT));
      blank_error  <= (blank_error & ~err_clear) | (latch_ev & ~output_enable_n);
    end
  end

  // Two-stage bank read: registered address, then registered data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= 4'd0;
      cap_data <= '0;
    end else begin
      addr_q   <= cap_lane_addr;
      cap_data <= ({1'b0, addr_q} < LANES_LIM) ? bank[addr_q] : '0;
    end
  end

endmodule

// File: tb/tb_led_serial_capture.sv
// tb/tb_led_serial_capture.sv - scoreboard bench for led_serial_capture
module tb_led_serial_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        serial_clk = 1'b0;
  logic        latch_enable = 1'b0;
  logic        output_enable_n = 1'b1;
  logic [11:0] serial_data_out = '0;
  logic [15:0] row_select_n = 16'hFFF7;
  logic [3:0]  cap_lane_addr = 4'd0;
  logic        err_clear = 1'b0;
  logic [15:0] cap_data;
  logic [3:0]  cap_row;
  logic [4:0]  cap_bit_count;
  logic        cap_strobe;
  logic [15:0] latch_count;
  logic        row_error;
  logic        length_error;
  logic        blank_error;

  led_serial_capture #(.LANES(12), .DEPTH(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .serial_clk(serial_clk),
    .latch_enable(latch_enable),
    .output_enable_n(output_enable_n),
    .serial_data_out(serial_data_out),
    .row_select_n(row_select_n),
    .cap_lane_addr(cap_lane_addr),
    .err_clear(err_clear),
    .cap_data(cap_data),
    .cap_row(cap_row),
    .cap_bit_count(cap_bit_count),
    .cap_strobe(cap_strobe),
    .latch_count(latch_count),
    .row_error(row_error),
    .length_error(length_error),
    .blank_error(blank_error)
  );

  always #10 clk = ~clk;

  // kind 0: latch metadata on cap_strobe, 1: cap_data read, 2: error flags
  typedef struct {
    int          kind;
    logic [15:0] data;
    logic [3:0]  row;
    logic [4:0]  cnt;
    logic [15:0] lc;
    logic [2:0]  flags;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_lc = 0;
  logic rd_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per DUT strobe or bench read window.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && (cap_strobe || rd_chk)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output strobe=%0b rd_chk=%0b", cap_strobe, rd_chk);
      end else begin
        e = sb.pop_front();
        if (cap_strobe) begin
          chk("strobe_kind", e.kind, 0);
          chk("cap_row", {28'd0, cap_row}, {28'd0, e.row});
          chk("cap_bit_count", {27'd0, cap_bit_count}, {27'd0, e.cnt});
          chk("latch_count", {16'd0, latch_count}, {16'd0, e.lc});
          chk("latch_flags", {29'd0, row_error, length_error, blank_error}, {29'd0, e.flags});
        end else if (e.kind == 1) begin
          chk("cap_data", {16'd0, cap_data}, {16'd0, e.data});
        end else begin
          chk("flags", {29'd0, row_error, length_error, blank_error}, {29'd0, e.flags});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic shift_bit(input logic b0, input logic b11);
    tick();
    serial_data_out     = '0;
    serial_data_out[0]  = b0;
    serial_data_out[11] = b11;
    serial_clk = 1'b1;
    tick();
    serial_clk = 1'b0;
  endtask

  task automatic shift_word(input logic [15:0] w0, input logic [15:0] w11, input int n);
    for (int k = 0; k < n; k++) begin
      shift_bit(w0[15-k], w11[15-k]);
    end
  endtask

  task automatic shift_ones(input int n);
    for (int k = 0; k < n; k++) begin
      shift_bit(1'b1, 1'b0);
    end
  endtask

  task automatic expect_latch(input logic [3:0] row, input logic [4:0] cnt, input logic [2:0] flags);
    exp_t e;
    exp_lc++;
    e.kind = 0; e.data = '0; e.row = row; e.cnt = cnt; e.lc = 16'(exp_lc); e.flags = flags;
    sb.push_back(e);
  endtask

  task automatic latch(input logic clr);
    tick();
    latch_enable = 1'b1;
    err_clear = clr;
    tick();
    latch_enable = 1'b0;
    err_clear = 1'b0;
  endtask

  task automatic read(input logic [3:0] a, input logic [15:0] exp);
    exp_t e;
    e.kind = 1; e.data = exp; e.row = '0; e.cnt = '0; e.lc = '0; e.flags = '0;
    sb.push_back(e);
    tick();
    cap_lane_addr = a;
    tick();
    tick();
    rd_chk = 1'b1;
    tick();
    rd_chk = 1'b0;
  endtask

  task automatic check_flags(input logic [2:0] flags);
    exp_t e;
    e.kind = 2; e.data = '0; e.row = '0; e.cnt = '0; e.lc = '0; e.flags = flags;
    sb.push_back(e);
    tick();
    rd_chk = 1'b1;
    tick();
    rd_chk = 1'b0;
  endtask

  task automatic clear_errors();
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_cap_data"}, {16'd0, cap_data}, 32'd0);
    chk({tag, "_cap_row"}, {28'd0, cap_row}, 32'd0);
    chk({tag, "_cap_bit_count"}, {27'd0, cap_bit_count}, 32'd0);
    chk({tag, "_cap_strobe"}, {31'd0, cap_strobe}, 32'd0);
    chk({tag, "_latch_count"}, {16'd0, latch_count}, 32'd0);
    chk({tag, "_flags"}, {29'd0, row_error, length_error, blank_error}, 32'd0);
  endtask

  initial begin
    check_idle("reset");
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (2) tick();

    // Nominal frame: row 3, lane 0 = A5C3, lane 11 = 0001
    shift_word(16'hA5C3, 16'h0001, 16);
    expect_latch(4'd3, 5'd16, 3'b000);
    latch(1'b0);
    read(4'd0, 16'hA5C3);
    read(4'd11, 16'h0001);
    read(4'd5, 16'h0000);

    // Short frame, then saturating long frame
    shift_ones(15);
    expect_latch(4'd3, 5'd15, 3'b010);
    latch(1'b0);
    shift_ones(40);
    expect_latch(4'd3, 5'd31, 3'b010);
    latch(1'b0);
    clear_errors();
    check_flags(3'b000);

    // Row errors: no row active, two rows active (6 and 7)
    row_select_n = 16'hFFFF;
    expect_latch(4'd0, 5'd0, 3'b110);
    latch(1'b0);
    row_select_n = 16'hFF3F;
    expect_latch(4'd6, 5'd0, 3'b110);
    latch(1'b0);
    clear_errors();
    check_flags(3'b000);
    row_select_n = 16'hFFF7;

    // Blank violation, then violation coinciding with err_clear
    output_enable_n = 1'b0;
    expect_latch(4'd3, 5'd0, 3'b011);
    latch(1'b0);
    clear_errors();
    check_flags(3'b000);
    expect_latch(4'd3, 5'd0, 3'b011);
    latch(1'b1);
    check_flags(3'b011);
    output_enable_n = 1'b1;
    clear_errors();
    check_flags(3'b000);

    // Final shift edge coincides with latch edge
    shift_word(16'hB00F, 16'h0000, 15);
    expect_latch(4'd3, 5'd16, 3'b000);
    tick();
    serial_data_out    = '0;
    serial_data_out[0] = 1'b1;
    serial_clk   = 1'b1;
    latch_enable = 1'b1;
    tick();
    serial_clk   = 1'b0;
    latch_enable = 1'b0;
    read(4'd0, 16'hB00F);
    read(4'd12, 16'h0000);
    read(4'd11, 16'h0000);

    // Reset mid-frame with serial_clk/latch_enable high across release
    shift_ones(8);
    tick();
    reset_n      = 1'b0;
    serial_clk   = 1'b1;
    latch_enable = 1'b1;
    exp_lc       = 0;
    cap_lane_addr = 4'd0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_idle("post_reset");
    tick();
    serial_clk   = 1'b0;
    latch_enable = 1'b0;
    tick();
    shift_word(16'hFFFF, 16'h0000, 16);
    expect_latch(4'd3, 5'd16, 3'b000);
    latch(1'b0);
    read(4'd0, 16'hFFFF);

    repeat (4) tick();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
